// File: rtl/picoblaze_io_pkg.sv
// Shared definitions for the sample-to-CPU interrupt feeder.
//   DEFAULT_DATA_W / DEFAULT_DEPTH : default sample width and FIFO depth
//   count_width()                  : width of an occupancy counter that can hold 0..depth
//   irq_state_t                    : interrupt sequencing FSM states
package picoblaze_io_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 8;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    REARM    = 2'd2
  } irq_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Register-array FIFO with a registered head-of-queue output.
//   clk, reset   : clock and synchronous active-high flush
//   push, push_data : write request and data (dropped when full unless popping)
//   pop          : remove head (ignored when empty)
//   data         : registered head entry, 0 while empty
//   count        : registered occupancy 0..DEPTH
//   push_ok, pop_ok : combinational "accepted this edge" qualifiers
//   empty_next   : occupancy after this edge will be zero
module feeder_fifo
  import picoblaze_io_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int CNT_W = count_width(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              push_ok,
  output logic              pop_ok,
  output logic              empty_next
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next, count_after_pop;
  logic [DATA_W-1:0] data_reg, data_next;

  always_comb begin
    pop_ok          = pop && (count_reg != '0);
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    push_ok         = push && ((count_reg != CNT_W'(DEPTH)) || pop_ok);
    count_after_pop = count_reg - CNT_W'(pop_ok);
    count_next      = count_after_pop + CNT_W'(push_ok);
    rd_ptr_next     = rd_ptr_reg + PTR_W'(pop_ok);
    wr_ptr_next     = wr_ptr_reg + PTR_W'(push_ok);
    empty_next      = (count_next == '0);
    // The head is precomputed so it can be registered: either the surviving
    // stored entry, or the incoming sample when it lands in an empty queue.
    // When full with push+pop, the push overwrites the slot being popped, but
    // the new head is at rd_ptr+1 which is untouched.
    data_next = '0;
    if (count_next != '0) begin
      if (count_after_pop == '0) begin
        data_next = push_data;
      end else begin
        data_next = mem_reg[rd_ptr_next];
      end
    end
  end

  // Storage is intentionally not reset; data is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      data_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      data_reg   <= data_next;
    end
  end

  assign data  = data_reg;
  assign count = count_reg;

endmodule

// File: rtl/sample_irq_feeder.sv
// Buffers acquisition samples for a small CPU and raises one interrupt pulse
// per entry presented on the CPU input port.
//   clk, reset         : clock and synchronous active-high reset
//   sample_data/strobe : incoming samples, no backpressure
//   read_ack           : CPU consumed the head entry
//   clear_overflow     : clears the sticky drop flag
//   input_data         : registered FIFO head (0 when empty)
//   external_interrupt : registered single-cycle interrupt request
//   fifo_count         : registered occupancy
//   overflow           : sticky "a sample was dropped"
module sample_irq_feeder
  import picoblaze_io_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_strobe,
  input  logic              read_ack,
  input  logic              clear_overflow,
  output logic [DATA_W-1:0] input_data,
  output logic              external_interrupt,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  logic       push_ok, pop_ok, empty_next;
  irq_state_t state_reg, state_next;
  logic       irq_reg, irq_next;
  logic       pend_reg, pend_next;
  logic       ovf_reg, ovf_next;

  feeder_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (sample_strobe),
    .push_data  (sample_data),
    .pop        (read_ack),
    .data       (input_data),
    .count      (fifo_count),
    .push_ok    (push_ok),
    .pop_ok     (pop_ok),
    .empty_next (empty_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      irq_reg   <= 1'b0;
      pend_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      irq_reg   <= irq_next;
      pend_reg  <= pend_next;
      ovf_reg   <= ovf_next;
    end
  end

  // The interrupt is registered, so it is visible in the first WAIT_ACK cycle
  // after each entry into WAIT_ACK. REARM is a guaranteed low cycle between
  // consecutive pulses. A pop seen while in REARM is remembered (pend_reg)
  // and resolved in the following WAIT_ACK cycle.
  always_comb begin
    state_next = state_reg;
    irq_next   = 1'b0;
    pend_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (push_ok) begin
          state_next = WAIT_ACK;
          irq_next   = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (pop_ok || pend_reg) begin
          state_next = empty_next ? IDLE : REARM;
        end
      end
      REARM: begin
        state_next = WAIT_ACK;
        irq_next   = 1'b1;
        pend_next  = pop_ok;
      end
      default: state_next = IDLE;
    endcase
  end

  // A drop on the same edge as a clear leaves the flag set.
  always_comb begin
    ovf_next = ovf_reg;
    if (sample_strobe && !push_ok) begin
      ovf_next = 1'b1;
    end else if (clear_overflow) begin
      ovf_next = 1'b0;
    end
  end

  assign external_interrupt = irq_reg;
  assign overflow           = ovf_reg;

endmodule

// File: doc/sample_irq_feeder.md
SAMPLE_IRQ_FEEDER -- requirements
Module: sample_irq_feeder

Interface
REQ-001 Parameter DATA_W, 8, sample and CPU read-port width.
REQ-002 Parameter DEPTH, 8, FIFO entries; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sample_data  input  DATA_W  sample from the acquisition source.
REQ-006 sample_strobe  input  1  one-cycle qualifier for sample_data; no backpressure.
REQ-007 read_ack  input  1  one-cycle pulse from the CPU port decode; pops the head entry.
REQ-008 clear_overflow  input  1  one-cycle pulse; clears the overflow flag.
REQ-009 input_data  output  DATA_W  registered head of FIFO, drives the CPU input-port mux.
REQ-010 external_interrupt  output  1  registered one-cycle interrupt request to the CPU.
REQ-011 fifo_count  output  $clog2(DEPTH)+1  registered occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag: a sample was dropped.

Function
REQ-013 Push: sample_strobe high at edge N with count<DEPTH (after any same-edge pop) SHALL store sample_data; count and input_data reflect it after edge N.
REQ-014 Pop: read_ack high at edge N with count>0 SHALL remove the head; the next entry is on input_data after edge N.
REQ-015 input_data SHALL equal the head entry while count>0 and SHALL be 0 while count=0.
REQ-016 FIFO order SHALL be strict first-in first-out; pointers wrap modulo DEPTH.
REQ-017 Simultaneous push and pop with count>0 SHALL leave count unchanged, including at count=DEPTH (push accepted, no overflow).
REQ-018 Simultaneous push and pop with count=0 SHALL ignore the pop and accept the push.
REQ-019 Push with count=DEPTH and no pop SHALL drop the sample, leave FIFO contents unchanged, and set overflow.
REQ-020 read_ack with count=0 SHALL be ignored (no pointer change, no underflow).
REQ-021 clear_overflow SHALL clear overflow; if a drop occurs in the same cycle, set wins.
REQ-022 Interrupt FSM states: IDLE, WAIT_ACK, REARM.
REQ-023 IDLE: when a push is accepted, SHALL go to WAIT_ACK and assert external_interrupt for exactly that one following cycle.
REQ-024 WAIT_ACK: external_interrupt low; on accepted pop leaving count>0 (including a same-edge push) SHALL go to REARM; on pop leaving count=0 SHALL go to IDLE.
REQ-025 REARM: SHALL assert external_interrupt for one cycle and go to WAIT_ACK; a pop in REARM SHALL be processed and its outcome applied per REQ-024 in WAIT_ACK on the next cycle.
REQ-026 Consequently one interrupt pulse per entry presented to the CPU; back-to-back pulses SHALL be separated by at least one low cycle.
REQ-027 Latency: accepted push into empty FIFO -> external_interrupt high in the cycle after the push edge; data already valid on input_data in that cycle.

Reset
REQ-028 reset at any edge SHALL flush the FIFO: count=0, pointers=0, input_data=0, external_interrupt=0, overflow=0, FSM=IDLE.
REQ-029 reset SHALL take priority over push, pop and clear_overflow in the same cycle; an in-flight interrupt pulse SHALL be cancelled.
REQ-030 FIFO storage contents need not be reset; no output may expose them while count=0.

Structure
REQ-031 Package picoblaze_io_pkg SHALL hold DATA_W/DEPTH defaults, count width function, and the FSM state typedef.
REQ-032 Storage and pointers SHALL be a sub-module feeder_fifo (push, pop, data, count); the FSM and overflow logic stay in the top.
REQ-033 Storage SHALL be a register array (no vendor RAM primitive); all outputs registered.

Verification
REQ-034 Reset, then push 0x11 -> next cycle input_data=0x11, fifo_count=1, external_interrupt high one cycle then low.
REQ-035 Push 0xA1,0xA2,0xA3 back-to-back, ack each 3 cycles later -> input_data sequence A1,A2,A3,0; exactly three interrupt pulses; FSM ends IDLE.
REQ-036 Push 9 samples into DEPTH=8 with no ack -> count=8, overflow=1, 9th sample absent; clear_overflow -> overflow=0.
REQ-037 At count=8, push 0x55 and read_ack same cycle -> count stays 8, overflow stays 0, 0x55 is read last.
REQ-038 read_ack at count=0, then simultaneous push 0x7E+ack at count=0 -> count=1, input_data=0x7E, one interrupt pulse.
REQ-039 Assert reset with count=5 during a REARM pulse -> next cycle all outputs 0, subsequent push gives fresh single interrupt.
